// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle control FSM for the 16-bit-instruction / 8-bit-data CPU
// datapath. Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
// Data memory accesses use a req/rdy handshake with a stall timeout. Retired
// instructions are counted.
//
// Parameters
//   MEM_TIMEOUT  cycles spent in MEM without mem_rdy before FAULT (1..255)
//   CNT_W        width of retire_cnt
//
// Optional feature (macro SEQ_SINGLE_STEP_EN)
//   Defined   : extra input 'step'. A retiring instruction enters FETCH only
//               on a cycle with step=1. Otherwise the FSM parks in a wait
//               that reports state=IDLE, busy=1, halted=0 until step=1.
//   Undefined : no step port, fetch runs freely.
//
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   start           leave IDLE/HALT and begin fetching
//   instr[15:0]     instruction word, opcode = instr[15:12] (read in DECODE)
//   alu_flags[3:0]  {N,Z,C,V}, Z used by BEQ in EXEC
//   mem_rdy         data memory completes its access this cycle
//   ir_we, pc_we    load IR / load PC
//   pc_src          0: PC+2, 1: branch target
//   reg_src[1:0]    register-address mux select (2'b10 for STR)
//   alu_src         0: rd2, 1: immediate
//   alu_ctrl[1:0]   00 ADD, 01 SUB, 10 AND, 11 OR
//   mem_req, mem_we data memory request and write qualifier
//   mem_to_reg      write-back source is memory
//   reg_we          register file write enable
//   busy/halted/fault, state[2:0]  status and current state encoding
//   retire_cnt      instructions retired since reset (wraps)
// ============================================================================
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic [3:0]       alu_flags,
  input  logic             mem_rdy,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       reg_src,
  output logic             alu_src,
  output logic [1:0]       alu_ctrl,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LDR  = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Timer counts down to zero, so a load of MEM_TIMEOUT-1 gives exactly
  // MEM_TIMEOUT cycles of MEM before the fault.
  localparam logic [7:0] TMO_LOAD = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
`ifdef SEQ_SINGLE_STEP_EN
  logic             wait_q, wait_d;
`endif

  function automatic logic op_legal(input logic [3:0] op);
    return (op[3:2] == 2'b00) || (op == OP_ADDI) || (op == OP_LDR) ||
           (op == OP_STR) || (op == OP_B) || (op == OP_BEQ) || (op == OP_HALT);
  endfunction

  // Classes of the opcode latched in DECODE; instr is not looked at afterwards.
  logic op_alu, op_addi, op_ldr, op_str, op_b, op_beq;
  assign op_alu  = (op_q[3:2] == 2'b00);
  assign op_addi = (op_q == OP_ADDI);
  assign op_ldr  = (op_q == OP_LDR);
  assign op_str  = (op_q == OP_STR);
  assign op_b    = (op_q == OP_B);
  assign op_beq  = (op_q == OP_BEQ);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    wait_d  = wait_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (wait_q) begin
          if (step) begin
            state_d = S_FETCH;
            wait_d  = 1'b0;
          end
        end else if (start) begin
          state_d = S_FETCH;
        end
`else
        if (start) state_d = S_FETCH;
`endif
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = instr[15:12];
        if (!op_legal(instr[15:12]))      state_d = S_FAULT;
        else if (instr[15:12] == OP_HALT) state_d = S_HALT;
        else                              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_alu || op_addi) begin
          state_d = S_WB;
        end else if (op_ldr || op_str) begin
          state_d = S_MEM;
          tmo_d   = TMO_LOAD;
        end else begin
          // Branches retire here.
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_rdy) begin
          if (op_str) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == 8'd0) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  if (start) state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

`ifdef SEQ_SINGLE_STEP_EN
    // Every transition into FETCH after a retire is gated by step.
    if (retire && !step) begin
      state_d = S_IDLE;
      wait_d  = 1'b1;
    end
`endif

    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      tmo_q   <= 8'd0;
      cnt_q   <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      wait_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_SINGLE_STEP_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs: decoded from the state register and latched opcode only
  // (BEQ additionally follows Z during EXEC), so reset clears them at once.
  // --------------------------------------------------------------------------
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_src    = 2'b00;
    alu_src    = 1'b0;
    alu_ctrl   = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        busy = wait_q;
`endif
      end
      S_FETCH: begin
        busy  = 1'b1;
        ir_we = 1'b1;
      end
      S_DECODE: begin
        busy  = 1'b1;
        pc_we = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (op_alu)  alu_ctrl = op_q[1:0];
        if (op_addi) alu_src  = 1'b1;
        if (op_str)  reg_src  = 2'b10;
        if (op_b) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
        if (op_beq) begin
          pc_we  = alu_flags[2];
          pc_src = alu_flags[2];
        end
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = op_str;
        if (op_str) reg_src = 2'b10;
      end
      S_WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        mem_to_reg = op_ldr;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: fault  = 1'b1;
    endcase
  end

  assign state      = state_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer
// ----------------------------------------------------------------------------
// Scoreboard bench. For each instruction issued, the reference model expands
// the instruction into its list of per-cycle phases and pushes the expected
// control/status word for each cycle into a queue. A separate monitor pops
// one entry per falling edge and compares it with the DUT outputs.
// retire_cnt is shrunk to 4 bits so the wrap is reached within the run.
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  localparam int CW  = 4;
  localparam int TMO = 15;

  // State encoding as published for the block.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3;
  localparam int P_MEM  = 4, P_WB    = 5, P_HALT   = 6, P_FAULT = 7;

  localparam int O_NEXT = 0, O_HALT = 1, O_FAULT = 2, O_CUT = 3;

  typedef struct packed {
    logic          ir_we;
    logic          pc_we;
    logic          pc_src;
    logic [1:0]    reg_src;
    logic          alu_src;
    logic [1:0]    alu_ctrl;
    logic          mem_req;
    logic          mem_we;
    logic          mem_to_reg;
    logic          reg_we;
    logic          busy;
    logic          halted;
    logic          fault;
    logic [2:0]    state;
    logic [CW-1:0] retire_cnt;
  } out_t;

  typedef struct {
    out_t w;
    int   idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   instr = 16'h0000;
  logic [3:0]    alu_flags = 4'h0;
  logic          mem_rdy = 1'b0;
  logic          ir_we, pc_we, pc_src, alu_src, mem_req, mem_we;
  logic          mem_to_reg, reg_we, busy, halted, fault;
  logic [1:0]    reg_src, alu_ctrl;
  logic [2:0]    state;
  logic [CW-1:0] retire_cnt;

  out_t          dut_w;
  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            n_instr = 0;
  int            outcome = O_NEXT;
  logic [CW-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .mem_rdy    (mem_rdy),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_src    (reg_src),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_to_reg (mem_to_reg),
    .reg_we     (reg_we),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .state      (state),
    .retire_cnt (retire_cnt)
  );

  always_comb dut_w = {ir_we, pc_we, pc_src, reg_src, alu_src, alu_ctrl, mem_req,
                       mem_we, mem_to_reg, reg_we, busy, halted, fault, state,
                       retire_cnt};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Expected outputs for one cycle spent in phase ph by an instruction with
  // opcode op, Z flag z, and the retire count visible during that cycle.
  function automatic out_t exp_word(input int ph, input logic [3:0] op,
                                    input logic z, input logic [CW-1:0] cnt);
    out_t w;
    w            = '0;
    w.state      = 3'(ph);
    w.retire_cnt = cnt;
    case (ph)
      P_FETCH:  begin w.busy = 1'b1; w.ir_we = 1'b1; end
      P_DECODE: begin w.busy = 1'b1; w.pc_we = 1'b1; end
      P_EXEC: begin
        w.busy = 1'b1;
        if (op[3:2] == 2'b00) w.alu_ctrl = op[1:0];
        if (op == 4'h4) w.alu_src = 1'b1;
        if (op == 4'h9) w.reg_src = 2'b10;
        if (op == 4'hC) begin w.pc_we = 1'b1; w.pc_src = 1'b1; end
        if (op == 4'hD) begin w.pc_we = z; w.pc_src = z; end
      end
      P_MEM: begin
        w.busy    = 1'b1;
        w.mem_req = 1'b1;
        w.mem_we  = (op == 4'h9);
        if (op == 4'h9) w.reg_src = 2'b10;
      end
      P_WB: begin
        w.busy       = 1'b1;
        w.reg_we     = 1'b1;
        w.mem_to_reg = (op == 4'h8);
      end
      P_HALT:  w.halted = 1'b1;
      P_FAULT: w.fault  = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

  // Called at posedge+1 of the cycle the DUT spends in FETCH. w = number of
  // MEM cycles before mem_rdy rises; max_cyc > 0 truncates the instruction.
  task automatic issue(input logic [15:0] ins, input logic [3:0] fl,
                       input int w, input int max_cyc);
    logic [3:0] op = ins[15:12];
    logic       legal;
    int         ph[$];
    int         n_mem;
    int         mem_i;
    exp_t       e;
    legal = (op[3:2] == 2'b00) || (op == 4'h4) || (op == 4'h8) || (op == 4'h9) ||
            (op == 4'hC) || (op == 4'hD) || (op == 4'hF);
    outcome = O_NEXT;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    if (!legal) begin
      outcome = O_FAULT;
    end else if (op == 4'hF) begin
      outcome = O_HALT;
    end else begin
      ph.push_back(P_EXEC);
      if (op[3:2] == 2'b00 || op == 4'h4) begin
        ph.push_back(P_WB);
      end else if (op == 4'h8 || op == 4'h9) begin
        n_mem = (w < TMO) ? w + 1 : TMO;
        repeat (n_mem) ph.push_back(P_MEM);
        if (w >= TMO) outcome = O_FAULT;
        else if (op == 4'h8) ph.push_back(P_WB);
      end
    end
    if (max_cyc > 0 && ph.size() > max_cyc) begin
      while (ph.size() > max_cyc) void'(ph.pop_back());
      outcome = O_CUT;
    end
    n_instr++;
    foreach (ph[i]) begin
      e.w   = exp_word(ph[i], op, fl[2], exp_cnt);
      e.idx = n_instr;
      exp_q.push_back(e);
    end
    mem_i = 0;
    instr = ins;
    foreach (ph[i]) begin
      start     = ($urandom_range(0, 3) == 0);
      alu_flags = (ph[i] == P_EXEC) ? fl : 4'($urandom);
      if (ph[i] == P_MEM) begin
        mem_rdy = (mem_i == w);
        mem_i++;
      end else begin
        mem_rdy = 1'($urandom);
      end
      // Opcode must already be latched once EXEC is reached.
      if (i >= 2) instr = 16'($urandom);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    mem_rdy = 1'b0;
    if (outcome == O_NEXT) exp_cnt++;
  endtask

  // Stay n cycles in an idle-like state; kick raises start on the last one.
  task automatic hold(input int n, input int ph, input logic kick, input logic rnd_start);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.w   = exp_word(ph, 4'h0, 1'b0, exp_cnt);
      e.idx = n_instr;
      exp_q.push_back(e);
      start   = kick ? (k == n - 1) : (rnd_start ? 1'($urandom) : 1'b0);
      mem_rdy = 1'($urandom);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    mem_rdy = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check(name, 32'(dut_w), 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic random_instr();
    int         k = $urandom_range(0, 5);
    logic [3:0] op;
    case (k)
      0:       op = 4'($urandom_range(0, 3));
      1:       op = 4'h4;
      2:       op = 4'h8;
      3:       op = 4'h9;
      4:       op = 4'hC;
      default: op = 4'hD;
    endcase
    issue({op, 12'($urandom)}, 4'($urandom), $urandom_range(0, 4), 0);
  endtask

  // Monitor: one expected word per cycle, compared away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("i%0d_st%0d", e.idx, e.w.state), 32'(dut_w), 32'(e.w));
      end
    end
  end

  initial begin
    #3;
    check("reset_outputs", 32'(dut_w), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    hold(2, P_IDLE, 1'b1, 1'b0);
    issue(16'h0123, 4'h0, 0, 0);          // ADD
    issue(16'hD000, 4'b1011, 0, 0);       // BEQ, Z=0
    issue(16'hD3F0, 4'b0100, 0, 0);       // BEQ, Z=1
    issue(16'h8012, 4'h0, 3, 0);          // LDR, rdy after 3 cycles
    issue(16'h9045, 4'h0, 0, 0);          // STR, immediate rdy
    issue(16'hC7FF, 4'h0, 0, 0);          // B
    issue(16'h4015, 4'h0, 0, 0);          // ADDI
    repeat (40) random_instr();

    issue(16'hF000, 4'h0, 0, 0);          // HALT
    hold(3, P_HALT, 1'b1, 1'b0);
    repeat (5) random_instr();

    issue(16'h9ABC, 4'h0, 100, 0);        // STR, mem_rdy never -> FAULT
    hold(4, P_FAULT, 1'b0, 1'b1);
    do_reset("rst_after_timeout");

    hold(2, P_IDLE, 1'b1, 1'b0);
    issue(16'h0321, 4'h0, 0, 0);
    issue(16'hA000, 4'h0, 0, 0);          // illegal -> FAULT
    hold(3, P_FAULT, 1'b0, 1'b1);
    do_reset("rst_after_illegal");

    hold(2, P_IDLE, 1'b1, 1'b0);
    issue(16'h1111, 4'h0, 0, 0);
    issue(16'h8555, 4'h0, 100, 5);        // stop in the 3rd MEM cycle
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    do_reset("rst_mid_mem");
    hold(2, P_IDLE, 1'b0, 1'b0);

    @(negedge clk); #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
